// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: register scoreboard with RAW/WAW stall detection,
// a saturating stall counter and a fixed-length flush after a taken branch.
module decode_issue_ctrl #(
    parameter int NREG         = 16,
    parameter int RW           = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int WB_BYPASS    = 1,
    parameter int CNTW         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_ra,
    input  logic [RW-1:0]   id_rb,
    input  logic            id_use_ra,
    input  logic            id_use_rb,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_wr,
    input  logic            id_branch,
    input  logic            pc_select,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    output logic            id_fire,
    output logic            stall,
    output logic            flush,
    output logic [NREG-1:0] pending,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [NREG-1:0] busy;
    logic            hazard;

    // A register stays busy until its writeback; with bypass the writeback cycle itself is hazard-free.
    // Set is applied after clear so a new write to the retiring register wins.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
        assign busy[gi] = pending_q[gi]
                        & ~((WB_BYPASS != 0) & wb_valid & (wb_rd == RW'(gi)));
        assign pending_d[gi] = (pending_q[gi] & ~(wb_valid & (wb_rd == RW'(gi))))
                             | (id_fire & id_wr & (id_rd == RW'(gi)));
    end

    assign hazard = (id_use_ra & busy[id_ra])
                  | (id_use_rb & busy[id_rb])
                  | (id_wr     & busy[id_rd]);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        id_fire     = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    id_fire = id_valid & ~hazard;
                    stall   = id_valid & hazard;
                    if (stall) begin
                        state_d = ST_STALL;
                    end else if (id_fire & id_branch & pc_select & (FLUSH_CYCLES > 0)) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FCW'(FLUSH_CYCLES);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                    if (flush_cnt_q <= FCW'(1)) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FCW'(1);
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pending   = pending_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: two configurations driven in parallel, directed
// scenarios followed by random traffic, all checked against a cycle-level rule model.
module tb_decode_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_use_ra, id_use_rb, id_wr, id_branch, pc_select, wb_valid;
    logic [3:0] id_ra, id_rb, id_rd, wb_rd;
    logic       fire0, stall0, flush0, fire1, stall1, flush1;
    logic [15:0] pend0, pend1, cnt1;
    logic [3:0]  cnt0;

    // Instance 0: bypass, 2-cycle flush, 4-bit counter. Instance 1: no bypass, no flush.
    decode_issue_ctrl #(.NREG(16), .RW(4), .FLUSH_CYCLES(2), .WB_BYPASS(1), .CNTW(4)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rd(id_rd), .id_wr(id_wr),
        .id_branch(id_branch), .pc_select(pc_select), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .id_fire(fire0), .stall(stall0), .flush(flush0), .pending(pend0), .stall_cnt(cnt0));

    decode_issue_ctrl #(.NREG(16), .RW(4), .FLUSH_CYCLES(0), .WB_BYPASS(0), .CNTW(16)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_rd(id_rd), .id_wr(id_wr),
        .id_branch(id_branch), .pc_select(pc_select), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .id_fire(fire1), .stall(stall1), .flush(flush1), .pending(pend1), .stall_cnt(cnt1));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [15:0] m_pend [2];
    int          m_fl   [2];
    int          m_cnt  [2];
    bit          e_fire [2];
    bit          e_stall[2];
    bit          e_flush[2];

    function automatic int cfg_fc(int k);   return (k == 0) ? 2 : 0;       endfunction
    function automatic bit cfg_byp(int k);  return (k == 0);               endfunction
    function automatic int cfg_cap(int k);  return (k == 0) ? 15 : 65535;  endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic bit busy(int k, logic [3:0] r);
        return m_pend[k][r] && !(cfg_byp(k) && wb_valid && (wb_rd == r));
    endfunction

    task automatic model_eval();
        bit hz;
        for (int k = 0; k < 2; k++) begin
            e_fire[k]  = 1'b0;
            e_stall[k] = 1'b0;
            e_flush[k] = 1'b0;
            if (!rst) begin
                if (m_fl[k] > 0) begin
                    e_flush[k] = 1'b1;
                end else begin
                    hz = (id_use_ra && busy(k, id_ra)) || (id_use_rb && busy(k, id_rb))
                      || (id_wr && busy(k, id_rd));
                    e_fire[k]  = id_valid && !hz;
                    e_stall[k] = id_valid && hz;
                end
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] = '0;
                m_fl[k]   = 0;
                m_cnt[k]  = 0;
            end else begin
                if (e_stall[k] && m_cnt[k] < cfg_cap(k)) m_cnt[k]++;
                if (m_fl[k] > 0) m_fl[k]--;
                else if (e_fire[k] && id_branch && pc_select && cfg_fc(k) > 0) m_fl[k] = cfg_fc(k);
                if (wb_valid) m_pend[k][wb_rd] = 1'b0;
                if (e_fire[k] && id_wr) m_pend[k][id_rd] = 1'b1;
            end
        end
    endtask

    // Inputs are driven at the falling edge; this samples, compares, then crosses one rising edge.
    task automatic step();
        #1;
        model_eval();
        check($sformatf("c%0d.fire0", cyc),  fire0,  e_fire[0]);
        check($sformatf("c%0d.stall0", cyc), stall0, e_stall[0]);
        check($sformatf("c%0d.flush0", cyc), flush0, e_flush[0]);
        check($sformatf("c%0d.pend0", cyc),  pend0,  m_pend[0]);
        check($sformatf("c%0d.cnt0", cyc),   cnt0,   m_cnt[0]);
        check($sformatf("c%0d.fire1", cyc),  fire1,  e_fire[1]);
        check($sformatf("c%0d.stall1", cyc), stall1, e_stall[1]);
        check($sformatf("c%0d.flush1", cyc), flush1, e_flush[1]);
        check($sformatf("c%0d.pend1", cyc),  pend1,  m_pend[1]);
        check($sformatf("c%0d.cnt1", cyc),   cnt1,   m_cnt[1]);
        $display("cyc %0d rst=%0b v=%0b ra=%0d/%0b rb=%0d/%0b rd=%0d/%0b br=%0b ps=%0b wb=%0b/%0d | f=%0b%0b s=%0b%0b fl=%0b%0b p0=%h p1=%h c0=%0d c1=%0d",
                 cyc, rst, id_valid, id_ra, id_use_ra, id_rb, id_use_rb, id_rd, id_wr,
                 id_branch, pc_select, wb_valid, wb_rd, fire0, fire1, stall0, stall1,
                 flush0, flush1, pend0, pend1, cnt0, cnt1);
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_use_ra = 0; id_use_rb = 0; id_wr = 0;
        id_branch = 0; pc_select = 0; wb_valid = 0;
        id_ra = 0; id_rb = 0; id_rd = 0; wb_rd = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_fl[k] = 0; m_cnt[k] = 0;
        end
        @(posedge clk);
        @(negedge clk);

        // Reset held with a valid instruction present
        rst = 1; id_valid = 1;
        step();
        step();

        // RAW: write r3, dependent read stalls until r3 writes back three cycles later
        idle(); id_valid = 1; id_wr = 1; id_rd = 3; step();
        idle(); id_valid = 1; id_use_ra = 1; id_ra = 3; step(); step();
        wb_valid = 1; wb_rd = 3;
        #1; check("raw.fire_in_wb", fire0, 1); check("raw.cnt_bypass", cnt0, 2);
        step();
        wb_valid = 0;
        #1; check("raw.fire_nobyp", fire1, 1); check("raw.cnt_nobyp", cnt1, 3);
        step();

        // WAW with same-cycle writeback: the new write must win
        idle(); id_valid = 1; id_wr = 1; id_rd = 5; step();
        wb_valid = 1; wb_rd = 5;
        #1; check("waw.fire", fire0, 1);
        step();
        idle();
        #1; check("waw.pend5", pend0[5], 1);
        step();
        wb_valid = 1; wb_rd = 5; step();
        idle(); step();

        // Taken branch, decode keeps presenting instructions during the flush
        idle(); id_valid = 1; id_branch = 1; pc_select = 1; step();
        id_branch = 0; pc_select = 0;
        #1; check("br.flush_c1", flush0, 1); check("br.nofire_c1", fire0, 0); check("br.fc0_noflush", flush1, 0);
        step();
        #1; check("br.flush_c2", flush0, 1); check("br.nofire_c2", fire0, 0);
        step();
        #1; check("br.flush_done", flush0, 0); check("br.fire_after", fire0, 1);
        step();
        id_branch = 1; pc_select = 0; step();
        idle();
        #1; check("br.not_taken", flush0, 0);
        step();

        // Reset in the first flush cycle with r3 and r6 in flight
        idle(); id_valid = 1; id_wr = 1; id_rd = 3; step();
        id_rd = 6; id_branch = 1; pc_select = 1; step();
        idle();
        #1; check("rstfl.flush", flush0, 1); check("rstfl.pend", pend0, 16'h0048);
        rst = 1; step();
        idle(); id_valid = 1;
        #1; check("rstfl.flush_off", flush0, 0); check("rstfl.pend_clr", pend0, 0); check("rstfl.run_fire", fire0, 1);
        step();

        // Stall counter saturation over 20 held stall cycles
        idle(); id_valid = 1; id_wr = 1; id_rd = 1; step();
        idle(); id_valid = 1; id_use_ra = 1; id_ra = 1;
        for (int i = 0; i < 20; i++) step();
        #1; check("sat.cnt", cnt0, 15);
        idle(); wb_valid = 1; wb_rd = 1; step();
        idle(); step();

        // Random traffic over a small register window so hazards are frequent
        for (int i = 0; i < 1200; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            id_valid  = ($urandom_range(0, 3) != 0);
            id_ra     = 4'($urandom_range(0, 7));
            id_rb     = 4'($urandom_range(0, 7));
            id_rd     = 4'($urandom_range(0, 7));
            id_use_ra = 1'($urandom_range(0, 1));
            id_use_rb = 1'($urandom_range(0, 1));
            id_wr     = 1'($urandom_range(0, 1));
            id_branch = ($urandom_range(0, 3) == 0);
            pc_select = 1'($urandom_range(0, 1));
            wb_valid  = 1'($urandom_range(0, 1));
            wb_rd     = 4'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
